// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer/response codes, arbiter state and
// data-phase owner encodings used by the two-master arbiter.
package ahb_pkg;

    // HTRANS transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HRESP response codes
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    // Arbiter states
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_OWN0 = 2'd1;
    localparam logic [1:0] ARB_OWN1 = 2'd2;

    // Data-phase owner
    localparam logic [1:0] DPH_NONE = 2'd0;
    localparam logic [1:0] DPH_M0   = 2'd1;
    localparam logic [1:0] DPH_M1   = 2'd2;

    // Master identifiers as used by the picker's last/winner
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // A transfer that actually moves data (NONSEQ or SEQ)
    function automatic logic isXfer(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Two-way request picker. Holds the only policy-dependent logic:
//   ARB_ROUND_ROBIN_EN defined   -> on contention grant the master that is not last
//   ARB_ROUND_ROBIN_EN undefined -> fixed priority, M0 always wins
module ahb_arb_pick
    import ahb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic valid
);

`ifndef ARB_ROUND_ROBIN_EN
    // last only matters for the rotating policy
    logic unusedLast;
    assign unusedLast = last;
`endif

    // Resolve the winner; winner is meaningful only while valid is high
    always_comb begin
        valid = req0 | req1;
`ifdef ARB_ROUND_ROBIN_EN
        winner = (req0 & req1) ? ~last : req1;
`else
        winner = (~req0 & req1) ? M1 : M0;
`endif
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB arbiter in front of the AHB2APB bridge.
// Muxes the address phase from the granted master, steers write data and
// HREADY/HRESP by data-phase owner, and forces a handover after MAX_HOLD
// transfers when the other master is waiting.
// Optional feature macro: ARB_ROUND_ROBIN_EN (see ahb_arb_pick).
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic              iHCLK,
    input  logic              iHRESET,
    input  logic              iREQ0,
    input  logic              iREQ1,
    input  logic [1:0]        iHTRANS0,
    input  logic [1:0]        iHTRANS1,
    input  logic [ADDR_W-1:0] iHADDR0,
    input  logic [ADDR_W-1:0] iHADDR1,
    input  logic              iHWRITE0,
    input  logic              iHWRITE1,
    input  logic [DATA_W-1:0] iHWDATA0,
    input  logic [DATA_W-1:0] iHWDATA1,
    output logic              oGNT0,
    output logic              oGNT1,
    output logic [1:0]        oHTRANS,
    output logic [ADDR_W-1:0] oHADDR,
    output logic              oHWRITE,
    output logic [DATA_W-1:0] oHWDATA,
    input  logic              iHREADY,
    input  logic [1:0]        iHRESP,
    input  logic [DATA_W-1:0] iHRDATA,
    output logic              oHREADY0,
    output logic              oHREADY1,
    output logic [1:0]        oHRESP0,
    output logic [1:0]        oHRESP1,
    output logic [DATA_W-1:0] oHRDATA
);

    localparam logic [2:0] HOLD_MAX = 3'(MAX_HOLD);

    logic [1:0] state, stNext;
    logic [1:0] dph, dphNext;
    logic [2:0] hold, holdNext;
    logic       last;
    logic       ownXfer;
    logic       pickWin, pickVld;
    logic       prioWin, prioVld;
    logic       m0Preempt;

    // Arbitration from IDLE
    ahb_arb_pick uPick (
        .req0   (iREQ0),
        .req1   (iREQ1),
        .last   (last),
        .winner (pickWin),
        .valid  (pickVld)
    );

    // Policy probe: with M1 competing and M0 marked as last, only fixed
    // priority still picks M0, which is exactly when M0 preempts an M1 owner.
    ahb_arb_pick uPrio (
        .req0   (iREQ0),
        .req1   (1'b1),
        .last   (M0),
        .winner (prioWin),
        .valid  (prioVld)
    );

    assign m0Preempt = prioVld & ~prioWin;

    // Address-phase mux from the granted master
    always_comb begin
        oHTRANS = HTRANS_IDLE;
        oHADDR  = '0;
        oHWRITE = 1'b0;
        case (state)
            ARB_OWN0: begin
                oHTRANS = iHTRANS0;
                oHADDR  = iHADDR0;
                oHWRITE = iHWRITE0;
            end
            ARB_OWN1: begin
                oHTRANS = iHTRANS1;
                oHADDR  = iHADDR1;
                oHWRITE = iHWRITE1;
            end
            default: ;
        endcase
    end

    // Hold count including the transfer completing at this edge, so the
    // handover lands right after the MAX_HOLD-th address phase.
    always_comb begin
        ownXfer  = isXfer(oHTRANS);
        holdNext = (ownXfer && hold != HOLD_MAX) ? hold + 3'd1 : hold;
        dphNext  = !ownXfer ? DPH_NONE : (state == ARB_OWN1) ? DPH_M1 : DPH_M0;
    end

    // Next-state selection (applied only on iHREADY=1 edges)
    always_comb begin
        stNext = state;
        case (state)
            ARB_IDLE: begin
                if (pickVld) stNext = pickWin ? ARB_OWN1 : ARB_OWN0;
            end
            ARB_OWN0: begin
                if (!iREQ0)                            stNext = iREQ1 ? ARB_OWN1 : ARB_IDLE;
                else if (iREQ1 && holdNext == HOLD_MAX) stNext = ARB_OWN1;
            end
            ARB_OWN1: begin
                if (!iREQ1)
                    stNext = iREQ0 ? ARB_OWN0 : ARB_IDLE;
                else if (iREQ0 && (holdNext == HOLD_MAX || m0Preempt))
                    stNext = ARB_OWN0;
            end
            default: stNext = ARB_IDLE;
        endcase
    end

    // Arbiter state, data-phase owner, hold counter and last grant; all
    // frozen while the bridge inserts wait states
    always_ff @(posedge iHCLK or posedge iHRESET) begin
        if (iHRESET) begin
            state <= ARB_IDLE;
            dph   <= DPH_NONE;
            hold  <= 3'd0;
            last  <= M1;
        end else if (iHREADY) begin
            state <= stNext;
            dph   <= dphNext;
            hold  <= (stNext != state || stNext == ARB_IDLE) ? 3'd0 : holdNext;
            if (stNext != state && stNext != ARB_IDLE)
                last <= (stNext == ARB_OWN1) ? M1 : M0;
        end
    end

    // Grant, data-phase steering and response routing
    always_comb begin
        oGNT0    = (state == ARB_OWN0);
        oGNT1    = (state == ARB_OWN1);
        oHWDATA  = (dph == DPH_M0) ? iHWDATA0 : (dph == DPH_M1) ? iHWDATA1 : '0;
        oHREADY0 = iHREADY & (oGNT0 | (dph == DPH_M0));
        oHREADY1 = iHREADY & (oGNT1 | (dph == DPH_M1));
        oHRESP0  = (dph == DPH_M0) ? iHRESP : HRESP_OKAY;
        oHRESP1  = (dph == DPH_M1) ? iHRESP : HRESP_OKAY;
        oHRDATA  = iHRDATA;
    end

endmodule

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Two-master AHB arbiter that shares the single AHB path into the AHB2APB bridge and GPIO between the LED control unit (master 0) and a second bus master (master 1, e.g. a debug/UART master). It grants the bus and multiplexes the address and control phase. It routes write data by data-phase owner, returns HREADY/HRESP to the owning master, and forces re-arbitration after a bounded number of transfers so neither master starves.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_HOLD, 4, completed transfers a master may own before forced handover when the other master requests (1..7)

Ports:
- iHCLK  in  1  bus clock
- iHRESET  in  1  asynchronous, active-high reset
- iREQ0 / iREQ1  in  1  bus request, master 0 / 1
- iHTRANS0 / iHTRANS1  in  2  transfer type per master
- iHADDR0 / iHADDR1  in  ADDR_W  address per master
- iHWRITE0 / iHWRITE1  in  1  write flag per master
- iHWDATA0 / iHWDATA1  in  DATA_W  write data per master
- oGNT0 / oGNT1  out  1  grant (registered, one-hot or both 0)
- oHTRANS  out  2  muxed transfer type to bridge
- oHADDR  out  ADDR_W  muxed address
- oHWRITE  out  1  muxed write flag
- oHWDATA  out  DATA_W  write data of data-phase owner
- iHREADY  in  1  ready from bridge
- iHRESP  in  2  response from bridge
- iHRDATA  in  DATA_W  read data from bridge
- oHREADY0 / oHREADY1  out  1  ready to master 0 / 1
- oHRESP0 / oHRESP1  out  2  response to master 0 / 1
- oHRDATA  out  DATA_W  iHRDATA broadcast to both masters

## Operation
- Arbiter states: IDLE, OWN0, OWN1. oGNTn = (state == OWNn).
- Address phase:
  - oHTRANS/oHADDR/oHWRITE come from the granted master.
  - In IDLE: oHTRANS = IDLE (2'b00), oHADDR = 0, oHWRITE = 0.
- Data-phase owner register dph ∈ {NONE, M0, M1}:
  - On a clock edge with iHREADY=1, dph takes the address-phase owner if its HTRANS is NONSEQ or SEQ; otherwise dph = NONE.
  - oHWDATA = iHWDATA of dph (0 when NONE).
- Ready and response routing:
  - oHREADYn = iHREADY when master n is the granted master or dph; otherwise 0.
  - oHRESPn = iHRESP when dph = n; otherwise OKAY.
  - ERROR, RETRY and SPLIT are only forwarded; the arbiter takes no action on them.
- State transitions are evaluated only on edges with iHREADY=1. When iHREADY=0, state, grant, dph and the hold counter all hold.
  - IDLE: go to OWN0 or OWN1 per the pick rule (Configuration); stay in IDLE if neither requests.
  - OWNn, iREQn=0: go to the other master if it requests, else IDLE.
  - OWNn, iREQn=1, other master requests, hold == MAX_HOLD: go to the other master.
  - Otherwise stay.
- Hold counter:
  - Increments on each iHREADY=1 edge where the owner drives NONSEQ/SEQ, saturating at MAX_HOLD.
  - Clears on any grant change and in IDLE.
- last register records the most recently granted master.
- Reset values:
  - state = IDLE, dph = NONE, hold = 0, last = M1 (so M0 wins first).
  - All outputs 0, except oHRESPn = OKAY.
- Reset mid-transfer: everything returns to reset values immediately. The in-flight data phase is abandoned and no response is routed.

## Timing
- Request to grant: iREQn sampled at edge k (IDLE, iHREADY=1); oGNTn is high after edge k. The master's first address appears on oHADDR in that same cycle (combinational mux).
- Handover costs no idle cycle. The old owner's last data phase overlaps the new owner's first address phase, and oHWDATA follows dph.
- Wait states: iHREADY=0 freezes grant and dph for as many cycles as it stays low.
- Simultaneous requests from IDLE resolve in a single cycle; grant never toggles without an iHREADY=1 edge.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on contention, the pick rule grants the master that is not `last`.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, M0 always wins.
  - Forced handover on MAX_HOLD still applies in OWN0, so M1 is not starved.
  - In OWN1, M0 preempts at the next iHREADY=1 edge regardless of hold.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS constants (IDLE/BUSY/SEQ/NONSEQ)
  - HRESP constants (OKAY/ERROR/SPLIT/RETRY)
  - the arbiter state enum and the dph encoding
- One sub-module, ahb_arb_pick: combinational two-way picker (inputs: req0, req1, last; output: winner, valid). It contains the only ARB_ROUND_ROBIN_EN-dependent logic.

## Test plan
- Reset, iREQ0=1 with NONSEQ write 0x8/0xF0, iHREADY=1 -> oGNT0=1 one edge after reset release; oHADDR=0x8; oHWDATA=0xF0 in the next cycle; oHRESP1=OKAY.
- Both masters request continuously, MAX_HOLD=4, iHREADY=1 -> exactly 4 M0 transfers, then OWN1 with no IDLE cycle. During the overlap cycle oHWDATA=iHWDATA0 while oHADDR=iHADDR1.
- iHREADY held low 3 cycles during OWN0 while iREQ1 rises -> grant, dph and oHADDR unchanged for 3 cycles; handover only on the next iHREADY=1 edge.
- Without ARB_ROUND_ROBIN_EN, in OWN1, iREQ0 rises -> OWN0 next iHREADY edge. With the macro, a simultaneous request from IDLE after last=M0 -> oGNT1=1.
- M1 read of 0x0 returns iHRESP=ERROR -> oHRESP1=ERROR, oHRESP0=OKAY; arbiter state unchanged.
- iHRESET asserted mid data phase in OWN1 -> oGNT1=0, oHTRANS=IDLE and oHWDATA=0 immediately (asynchronous).
